// File: rtl/lru_tree_walker.sv
// -----------------------------------------------------------------------------
// lru_tree_walker
//   Tree-PLRU state owner for one cache set. An accepted hit walks the
//   heap-indexed PLRU tree from the hit way's leaf up to the root, one level
//   per clock. Each visited internal node is rewritten to point away from the
//   accessed subtree. The current victim way is presented continuously.
//
//   Optional build macro: LRU_TREE_ONECYCLE_EN
//     defined   -> the whole leaf-to-root path is written at the accept edge,
//                  and a hit can be accepted every cycle.
//     undefined -> iterative walk, one level per edge (default).
//   Final lru_bits are identical in both builds for any hit sequence.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst_n        in   synchronous active-low reset
//   hit_valid    in   hit request
//   hit_way      in   accessed way, sampled only at accept
//   hit_ready    out  hit accepted when hit_valid && hit_ready
//   invalidate   in   clear whole tree, abort any walk (wins over a hit)
//   update_done  out  registered 1-cycle pulse, lru_bits final
//   lru_bits     out  internal node bits, bit i = heap node i (root = 0)
//   victim_way   out  way reached by following lru_bits from the root
//   victim_valid out  victim_way stable (no walk in progress)
// -----------------------------------------------------------------------------
module lru_tree_walker #(
  parameter int s_assoc = 8,
  parameter int s_width = $clog2(s_assoc)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hit_valid,
  input  logic [s_width-1:0] hit_way,
  output logic               hit_ready,
  input  logic               invalidate,
  output logic               update_done,
  output logic [s_assoc-2:0] lru_bits,
  output logic [s_width-1:0] victim_way,
  output logic               victim_valid
);

  // Node indices span leaves up to 2*s_assoc-2, so one extra bit is needed.
  localparam int NW = s_width + 1;
  typedef logic [NW-1:0] node_t;
  localparam node_t LEAF_BASE = node_t'(s_assoc - 1);

  // Read one internal node bit; leaf indices read as 0.
  function automatic logic rd_bit(input logic [s_assoc-2:0] b, input node_t n);
    rd_bit = 1'b0;
    for (int i = 0; i < s_assoc - 1; i++) begin
      if (node_t'(i) == n) rd_bit = b[i];
    end
  endfunction

  // Return b with internal node n set to v; other bits untouched.
  function automatic logic [s_assoc-2:0] wr_bit(input logic [s_assoc-2:0] b,
                                                input node_t n, input logic v);
    wr_bit = b;
    for (int i = 0; i < s_assoc - 1; i++) begin
      if (node_t'(i) == n) wr_bit[i] = v;
    end
  endfunction

  logic [s_assoc-2:0] lru_q, lru_d;
  logic               done_q, done_d;
  logic               accept_s;
  node_t              leaf_s;
  node_t              vn_s;

`ifdef LRU_TREE_ONECYCLE_EN
  node_t oc_n_s, oc_p_s;
`else
  typedef enum logic {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_e;
  state_e state_q, state_d;
  node_t  node_q, node_d;
  node_t  walk_p_s;
`endif

  // Victim descent: bit 1 steers to the right child (2n+2), 0 to the left.
  always_comb begin
    vn_s = '0;
    for (int l = 0; l < s_width; l++) begin
      vn_s = rd_bit(lru_q, vn_s) ? ((vn_s << 1) + node_t'(2))
                                 : ((vn_s << 1) + node_t'(1));
    end
    victim_way = s_width'(vn_s - LEAF_BASE);
  end

  // Next-state logic for the tree bits, walk pointer and done pulse.
  always_comb begin
    leaf_s = node_t'(hit_way) + LEAF_BASE;
    lru_d  = lru_q;
    done_d = 1'b0;
`ifdef LRU_TREE_ONECYCLE_EN
    hit_ready    = ~invalidate;
    victim_valid = 1'b1;
    accept_s     = hit_valid & hit_ready;
    oc_n_s       = leaf_s;
    oc_p_s       = '0;
    if (invalidate) begin
      lru_d = '0;
    end else if (accept_s) begin
      // Whole path in one go; a left child (odd) makes the parent point right.
      for (int l = 0; l < s_width; l++) begin
        oc_p_s = (oc_n_s - node_t'(1)) >> 1;
        lru_d  = wr_bit(lru_d, oc_p_s, oc_n_s[0]);
        oc_n_s = oc_p_s;
      end
      done_d = 1'b1;
    end else begin
      lru_d = lru_q;
    end
`else
    hit_ready    = (state_q == ST_IDLE) & ~invalidate;
    victim_valid = (state_q == ST_IDLE);
    accept_s     = hit_valid & hit_ready;
    state_d      = state_q;
    node_d       = node_q;
    walk_p_s     = (node_q - node_t'(1)) >> 1;
    if (invalidate) begin
      lru_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            node_d  = leaf_s;
            state_d = ST_WALK;
          end else begin
            node_d = node_q;
          end
        end
        ST_WALK: begin
          // One level per edge; odd node is a left child -> parent bit 1.
          lru_d  = wr_bit(lru_q, walk_p_s, node_q[0]);
          node_d = walk_p_s;
          if (walk_p_s == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WALK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lru_q  <= '0;
      done_q <= 1'b0;
`ifndef LRU_TREE_ONECYCLE_EN
      state_q <= ST_IDLE;
      node_q  <= '0;
`endif
    end else begin
      lru_q  <= lru_d;
      done_q <= done_d;
`ifndef LRU_TREE_ONECYCLE_EN
      state_q <= state_d;
      node_q  <= node_d;
`endif
    end
  end

  assign lru_bits    = lru_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_lru_tree_walker.sv
// Scoreboard bench for lru_tree_walker (s_assoc = 8, iterative build).
// Expected tree states below are hand-derived from the walk rule: on the
// path from leaf (way+7) to the root, parent bit = 1 when the child is odd.
module tb_lru_tree_walker;

  localparam int A = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hit_valid = 1'b0;
  logic [W-1:0] hit_way = '0;
  logic         invalidate = 1'b0;
  logic         hit_ready;
  logic         update_done;
  logic [A-2:0] lru_bits;
  logic [W-1:0] victim_way;
  logic         victim_valid;

  lru_tree_walker #(.s_assoc(A), .s_width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hit_valid   (hit_valid),
    .hit_way     (hit_way),
    .hit_ready   (hit_ready),
    .invalidate  (invalidate),
    .update_done (update_done),
    .lru_bits    (lru_bits),
    .victim_way  (victim_way),
    .victim_valid(victim_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A-2:0] lru;
    logic [W-1:0] vic;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pops one expectation per update_done pulse.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (update_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update_done", 32'd1, 32'd0);
        end else begin
          exp_t e = exp_q.pop_front();
          chk("done_lru_bits", 32'(lru_bits), 32'(e.lru));
          chk("done_victim_way", 32'(victim_way), 32'(e.vic));
          chk("done_victim_valid", 32'(victim_valid), 32'd1);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] w, input bit push, input exp_t e,
                      output int waited, output logic done_seen);
    hit_valid = 1'b1;
    hit_way   = w;
    waited    = 0;
    done_seen = 1'b0;
    while (hit_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (hit_ready !== 1'b1) begin
      chk("accept_timeout", 32'd0, 32'd1);
      hit_valid = 1'b0;
    end else begin
      done_seen = update_done;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      hit_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [W-1:0] ways [6] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd7, 3'd1};
  logic [A-2:0] lrus [6] = '{7'h0B, 7'h2E, 7'h3D, 7'h78, 7'h38, 7'h33};
  logic [W-1:0] vics [6] = '{3'd4, 3'd2, 3'd6, 3'd1, 3'd1, 3'd5};

  initial begin
    exp_t e;
    int   wt;
    logic dn;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_lru_bits", 32'(lru_bits), 32'h00);
    chk("rst_victim_way", 32'(victim_way), 32'd0);
    chk("rst_victim_valid", 32'(victim_valid), 32'd1);
    chk("rst_hit_ready", 32'(hit_ready), 32'd1);
    chk("rst_update_done", 32'(update_done), 32'd0);

    // Back-to-back hit stream; each later hit lands in the previous done cycle.
    for (int i = 0; i < 6; i++) begin
      e.lru = lrus[i];
      e.vic = vics[i];
      send(ways[i], 1'b1, e, wt, dn);
      if (i == 0) begin
        chk("first_accept_wait", 32'(wt), 32'd0);
      end else begin
        chk("ready_low_cycles", 32'(wt), 32'd3);
        chk("accept_in_done_cycle", 32'(dn), 32'd1);
      end
    end
    drain();

    // Invalidate after the first level write of a way-3 walk (tree 7'h33).
    e = '0;
    send(3'd3, 1'b0, e, wt, dn);
    @(negedge clk);
    chk("walk_first_level", 32'(lru_bits), 32'h23);
    chk("walk_victim_valid", 32'(victim_valid), 32'd0);
    invalidate = 1'b1;
    #1;
    chk("inv_hit_ready", 32'(hit_ready), 32'd0);
    @(negedge clk);
    invalidate = 1'b0;
    #1;
    chk("inv_lru_bits", 32'(lru_bits), 32'h00);
    chk("inv_hit_ready_after", 32'(hit_ready), 32'd1);
    chk("inv_update_done", 32'(update_done), 32'd0);

    // Invalidate together with a hit: the hit must not be taken.
    hit_valid  = 1'b1;
    hit_way    = 3'd3;
    invalidate = 1'b1;
    #1;
    chk("inv_hit_collide_ready", 32'(hit_ready), 32'd0);
    @(negedge clk);
    hit_valid  = 1'b0;
    invalidate = 1'b0;
    #1;
    chk("inv_hit_not_walking", 32'(hit_ready), 32'd1);
    chk("inv_hit_lru", 32'(lru_bits), 32'h00);
    repeat (5) @(negedge clk);

    // Reset in the middle of a way-2 walk (first level sets bit 4).
    send(3'd2, 1'b0, e, wt, dn);
    @(negedge clk);
    chk("walk2_first_level", 32'(lru_bits), 32'h10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_lru_bits", 32'(lru_bits), 32'h00);
    chk("midrst_update_done", 32'(update_done), 32'd0);
    chk("midrst_hit_ready", 32'(hit_ready), 32'd1);
    chk("midrst_victim_way", 32'(victim_way), 32'd0);
    chk("midrst_victim_valid", 32'(victim_valid), 32'd1);
    repeat (5) @(negedge clk);

    // Recovery: a fresh hit on way 0 behaves as after power-up.
    e.lru = 7'h0B;
    e.vic = 3'd4;
    send(3'd0, 1'b1, e, wt, dn);
    chk("recover_accept_wait", 32'(wt), 32'd0);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
